// File: rtl/cc1200_spi_pkg.sv
// Shared types and constants for the CC1200-style SPI responder.
package cc1200_spi_pkg;
  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 8;

  // Header byte layout: R/W flag, burst flag, then the register address.
  localparam int HDR_RW_BIT    = 7;
  localparam int HDR_BURST_BIT = 6;

  // Status byte layout: {CHIP_RDYn, STATE[2:0], 4'b0}.
  localparam int STAT_RDYN_BIT  = 7;
  localparam int STAT_STATE_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  function automatic logic [7:0] status_byte(input logic rdyn, input logic [2:0] state);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_RDYN_BIT] = rdyn;
    s[STAT_STATE_LSB +: 3] = state;
    return s;
  endfunction
endpackage

// File: rtl/spi_in_sync.sv
// Synchronises the SPI pins into clk and flags single-cycle edges.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclk_in,
  input  logic mosi_in,
  input  logic cs_n_in,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
  logic sclk_q, cs_q;

  // Synchroniser chains plus one extra flop for edge detection; CS_n idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk_in};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi_in};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n_in};
      sclk_q  <= sclk_sr[SYNC_STAGES-1];
      cs_q    <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign mosi      = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_q;
  assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_q;
  assign cs_rise   =  cs_sr[SYNC_STAGES-1] & ~cs_q;
  assign cs_fall   = ~cs_sr[SYNC_STAGES-1] &  cs_q;
endmodule

// File: rtl/cc1200_spi_responder.sv
// CC1200-style register file behind a mode-0 SPI responder port.
module cc1200_spi_responder
  import cc1200_spi_pkg::*;
#(
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               DATA_W      = DATA_W_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_FILL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS_n,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [2:0]        status_state,
  input  logic              chip_rdyn,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [DATA_W-1:0] mon_data
);
  localparam int CNT_W = $clog2(DATA_W);

  logic mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .sclk_in   (SCLK),
    .mosi_in   (MOSI),
    .cs_n_in   (CS_n),
    .mosi      (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  spi_state_e        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, rx_byte;
  logic              tx_hold;
  logic              rw, burst;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic              byte_done, reg_we;
  logic [DATA_W-1:0] regs [2**ADDR_W];

  assign rx_byte   = {rx_sr[DATA_W-2:0], mosi_s};
  assign byte_done = sclk_rise && (state != ST_IDLE) && (bit_cnt == CNT_W'(DATA_W-1));
  assign reg_we    = byte_done && (state == ST_DATA) && !rw;
  assign addr_inc  = addr + 1'b1;

  assign MISO_oe  = (state != ST_IDLE);
  assign MISO     = ((state == ST_HEADER) || (state == ST_DATA)) ? tx_sr[DATA_W-1] : 1'b0;
  assign mon_data = regs[mon_addr];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a completed byte is acted on before a coincident CS_n rise aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cs_fall)             state_nxt = ST_HEADER;
      ST_HEADER: if (byte_done)           state_nxt = ST_DATA;
      ST_DATA:   if (byte_done && !burst) state_nxt = ST_IGNORE;
      default:   state_nxt = state;
    endcase
    if (cs_rise) state_nxt = ST_IDLE;
  end

  // Shift registers, header decode, read fetch and write strobe.
  // tx_hold skips the SCLK fall that follows a byte-boundary load, so the
  // freshly loaded MSB is still on MISO at the next rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      tx_hold <= 1'b0;
      rw      <= 1'b0;
      burst   <= 1'b0;
      addr    <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (state == ST_IDLE) begin
        if (cs_fall) begin
          tx_sr   <= DATA_W'(status_byte(chip_rdyn, status_state));
          bit_cnt <= '0;
          tx_hold <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (sclk_fall) begin
          if (tx_hold) tx_hold <= 1'b0;
          else         tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
        end
        if (byte_done) begin
          if (state == ST_HEADER) begin
            rw    <= rx_byte[HDR_RW_BIT];
            burst <= rx_byte[HDR_BURST_BIT];
            addr  <= rx_byte[ADDR_W-1:0];
            if (rx_byte[HDR_RW_BIT]) begin
              tx_sr   <= regs[rx_byte[ADDR_W-1:0]];
              tx_hold <= 1'b1;
            end
          end else if (state == ST_DATA) begin
            if (!rw) begin
              wr_stb  <= 1'b1;
              wr_addr <= addr;
              wr_data <= rx_byte;
            end else if (burst) begin
              tx_sr   <= regs[addr_inc];
              tx_hold <= 1'b1;
            end
            if (burst) addr <= addr_inc;
          end
        end
        if (cs_rise) begin
          bit_cnt <= '0;
          tx_hold <= 1'b0;
        end
      end
    end
  end

  // Register array; writes land on the same edge the data byte completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= RESET_FILL;
    end else if (reg_we) begin
      regs[addr] <= rx_byte;
    end
  end
endmodule

// File: tb/tb_cc1200_spi_responder.sv
// Self-checking bench for cc1200_spi_responder.
module tb_cc1200_spi_responder;
  localparam int        HP   = 6;      // SCLK half period in clk cycles
  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       SCLK = 1'b0, MOSI = 1'b0, CS_n = 1'b1;
  logic       MISO, MISO_oe;
  logic [2:0] status_state = 3'b000;
  logic       chip_rdyn = 1'b0;
  logic       wr_stb;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] mon_addr = 6'd0;
  logic [7:0] mon_data;

  int total = 0, bad = 0;
  logic [13:0] stb_q[$];
  logic [13:0] stb_exp;
  logic [7:0]  miso_q[$];
  logic [7:0]  model [64];

  cc1200_spi_responder #(.ADDR_W(6), .DATA_W(8), .SYNC_STAGES(2), .RESET_FILL(FILL)) dut (
    .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .status_state(status_state), .chip_rdyn(chip_rdyn),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .mon_addr(mon_addr), .mon_data(mon_data)
  );

  always #5 clk = ~clk;

  // Write-strobe scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && wr_stb) begin
      total++;
      if (stb_q.size() == 0) begin
        bad++;
        $display("FAIL wr_stb_unexpected got addr=%0h data=%0h want none", wr_addr, wr_data);
      end else begin
        stb_exp = stb_q.pop_front();
        if ({wr_addr, wr_data} !== stb_exp) begin
          bad++;
          $display("FAIL wr_stb got addr=%0h data=%0h want addr=%0h data=%0h",
                   wr_addr, wr_data, stb_exp[13:8], stb_exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the top nb bits of tx, capturing MISO at each SCLK rise.
  task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      MOSI = tx[i];
      clks(HP);
      rx[i] = MISO;
      SCLK = 1'b1;
      clks(HP);
      SCLK = 1'b0;
    end
  endtask

  task automatic xfer_chk(input string nm, input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    miso_q.push_back(exp);
    xfer(tx, 8, rx);
    chk(nm, rx, miso_q.pop_front());
  endtask

  // Data byte of a write: expect a strobe and update the model.
  task automatic wbyte(input string nm, input logic [5:0] a, input logic [7:0] d, input logic [7:0] exp_miso);
    stb_q.push_back({a, d});
    model[a] = d;
    xfer_chk(nm, d, exp_miso);
  endtask

  task automatic cs_low();
    CS_n = 1'b0;
    clks(HP);
  endtask

  task automatic cs_high();
    clks(HP);
    CS_n = 1'b1;
    clks(HP);
  endtask

  task automatic mon_chk(input string nm, input logic [5:0] a);
    mon_addr = a;
    #1;
    chk(nm, mon_data, model[a]);
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic [2:0] st;
    logic       rdyn;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] stat, rx;

  initial begin
    vecs[0] = '{6'h12, 8'h3C, 3'b001, 1'b0};
    vecs[1] = '{6'h3F, 8'hFF, 3'b111, 1'b1};
    vecs[2] = '{6'h00, 8'h81, 3'b000, 1'b0};
    vecs[3] = '{6'h2A, 8'h00, 3'b101, 1'b1};
    for (int i = 0; i < 64; i++) model[i] = FILL;

    // Reset state
    clks(3);
    chk("rst_miso", MISO, 1'b0);
    chk("rst_miso_oe", MISO_oe, 1'b0);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 6'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    mon_chk("rst_reg9", 6'd9);
    rstn = 1'b1;
    clks(3);

    // 1: single write
    status_state = 3'b000; chip_rdyn = 1'b0;
    cs_low();
    chk("t1_miso_oe", MISO_oe, 1'b1);
    xfer_chk("t1_hdr_status", 8'h05, 8'h00);
    wbyte("t1_data_miso", 6'h05, 8'hA5, 8'h00);
    cs_high();
    chk("t1_oe_off", MISO_oe, 1'b0);
    chk("t1_stb_left", stb_q.size(), 0);
    mon_chk("t1_reg5", 6'h05);

    // 2: burst write wrapping 3F -> 00
    cs_low();
    xfer_chk("t2_hdr", 8'h7E, 8'h00);
    wbyte("t2_d0", 6'h3E, 8'h11, 8'h00);
    wbyte("t2_d1", 6'h3F, 8'h22, 8'h00);
    wbyte("t2_d2", 6'h00, 8'h33, 8'h00);
    cs_high();
    chk("t2_stb_left", stb_q.size(), 0);
    mon_chk("t2_reg3e", 6'h3E);
    mon_chk("t2_reg3f", 6'h3F);
    mon_chk("t2_reg00", 6'h00);

    // 3: single read with status byte
    status_state = 3'b010; chip_rdyn = 1'b0;
    cs_low();
    xfer_chk("t3_status", 8'h85, 8'h20);
    xfer_chk("t3_data", 8'h00, 8'hA5);
    cs_high();

    // 4: non-burst overrun, then read with overrun
    cs_low();
    xfer_chk("t4_hdr", 8'h05, 8'h20);
    wbyte("t4_d0", 6'h05, 8'h5A, 8'h00);
    xfer_chk("t4_extra", 8'hFF, 8'h00);
    cs_high();
    chk("t4_stb_left", stb_q.size(), 0);
    mon_chk("t4_reg6", 6'h06);
    cs_low();
    xfer_chk("t4_rd_status", 8'h85, 8'h20);
    xfer_chk("t4_rd_data", 8'h00, 8'h5A);
    xfer_chk("t4_rd_ignore", 8'h00, 8'h00);
    cs_high();

    // Burst read across the wrap
    cs_low();
    xfer_chk("br_status", 8'hFF, 8'h20);
    xfer_chk("br_d0", 8'h00, model[6'h3F]);
    xfer_chk("br_d1", 8'h00, model[6'h00]);
    cs_high();

    // 5: abort mid data byte, then a normal frame
    cs_low();
    xfer_chk("t5_hdr", 8'h07, 8'h20);
    xfer(8'hC3, 4, rx);
    cs_high();
    chk("t5_oe", MISO_oe, 1'b0);
    mon_chk("t5_reg7", 6'h07);
    clks(4);
    chk("t5_no_stb", stb_q.size(), 0);
    cs_low();
    xfer_chk("t5_next_hdr", 8'h07, 8'h20);
    wbyte("t5_next_d", 6'h07, 8'h3C, 8'h00);
    cs_high();
    mon_chk("t5_reg7_new", 6'h07);

    // Table-driven write/read-back with varying status
    for (int v = 0; v < 4; v++) begin
      status_state = vecs[v].st;
      chip_rdyn    = vecs[v].rdyn;
      stat = {vecs[v].rdyn, vecs[v].st, 4'b0000};
      cs_low();
      xfer_chk("vec_wr_status", {2'b00, vecs[v].addr}, stat);
      wbyte("vec_wr_data", vecs[v].addr, vecs[v].data, 8'h00);
      cs_high();
      mon_chk("vec_mon", vecs[v].addr);
      cs_low();
      xfer_chk("vec_rd_status", {2'b10, vecs[v].addr}, stat);
      xfer_chk("vec_rd_data", 8'h00, vecs[v].data);
      cs_high();
    end

    // 6: reset in the middle of a burst write
    status_state = 3'b000; chip_rdyn = 1'b0;
    cs_low();
    xfer_chk("t6_hdr", 8'h50, 8'h00);
    wbyte("t6_d0", 6'h10, 8'h77, 8'h00);
    clks(HP);
    chk("t6_stb_left", stb_q.size(), 0);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) model[i] = FILL;
    chk("t6_oe", MISO_oe, 1'b0);
    chk("t6_miso", MISO, 1'b0);
    mon_chk("t6_reg10", 6'h10);
    mon_chk("t6_reg05", 6'h05);
    CS_n = 1'b1;
    clks(4);
    rstn = 1'b1;
    clks(4);
    cs_low();
    xfer_chk("t6_rd_status", 8'h80, 8'h00);
    xfer_chk("t6_rd_data", 8'h00, FILL);
    cs_high();

    clks(10);
    chk("end_stb_left", stb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
